// File: rtl/core_reset_sequencer.sv
// core_reset_sequencer: orders reset release after the board/PLL reset request drops.
// ether_reset_out releases first, then core_reset_out, then ready.
// The fan turns on at ETHER entry and stays on until reset.
// Optional macro FAN_PWM_EN: fan_en becomes a PWM waveform
// (FAN_PWM_DUTY high cycles out of every FAN_PWM_PERIOD cycles).
module core_reset_sequencer #(
    parameter int HOLD_CYCLES    = 16,
    parameter int ETHER_DELAY    = 8,
    parameter int CORE_DELAY     = 8,
    parameter int FAN_PWM_PERIOD = 100,
    parameter int FAN_PWM_DUTY   = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic reset_req,
    output logic ether_reset_out,
    output logic core_reset_out,
    output logic fan_en,
    output logic ready
);

    // A zero parameter is treated as one, so every terminal count is at least 0.
    localparam int HOLD_N   = (HOLD_CYCLES    == 0) ? 1 : HOLD_CYCLES;
    localparam int ETHER_N  = (ETHER_DELAY    == 0) ? 1 : ETHER_DELAY;
    localparam int CORE_N   = (CORE_DELAY     == 0) ? 1 : CORE_DELAY;

    localparam logic [15:0] HOLD_TC  = 16'(HOLD_N - 1);
    localparam logic [15:0] ETHER_TC = 16'(ETHER_N - 1);
    localparam logic [15:0] CORE_TC  = 16'(CORE_N - 1);

    // Every count must fit the shared 16-bit counters.
    if (HOLD_CYCLES > 65536 || ETHER_DELAY > 65536 || CORE_DELAY > 65536 ||
        FAN_PWM_PERIOD > 65536 || FAN_PWM_DUTY < 0) begin : g_param_range
        $error("core_reset_sequencer: parameter out of 16-bit range");
    end

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        ETHER = 2'd1,
        CORE  = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        req_meta, req_sync;
    logic        fan_on, fan_on_nxt;
    logic        fan_nxt;

    // Two-flop synchronizer. It powers up asserted, so the sequence starts held.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_meta <= 1'b1;
            req_sync <= 1'b1;
        end else begin
            req_meta <= reset_req;
            req_sync <= req_meta;
        end
    end

    // Next state and counter. A request always wins over a terminal count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 16'd1;
        case (state)
            HOLD: begin
                if (req_sync) begin
                    cnt_nxt = '0;
                end else if (cnt == HOLD_TC) begin
                    state_nxt = ETHER;
                    cnt_nxt   = '0;
                end
            end
            ETHER: begin
                if (req_sync) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else if (cnt == ETHER_TC) begin
                    state_nxt = CORE;
                    cnt_nxt   = '0;
                end
            end
            CORE: begin
                if (req_sync) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else if (cnt == CORE_TC) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (req_sync) state_nxt = HOLD;
            end
            default: begin
                state_nxt = HOLD;
                cnt_nxt   = '0;
            end
        endcase
        fan_on_nxt = fan_on | (state == HOLD && state_nxt == ETHER);
    end

`ifdef FAN_PWM_EN
    localparam int PERIOD_N = (FAN_PWM_PERIOD == 0) ? 1 : FAN_PWM_PERIOD;
    localparam int DUTY_N   = (FAN_PWM_DUTY   == 0) ? 1 : FAN_PWM_DUTY;
    localparam logic [15:0] PWM_TC = 16'(PERIOD_N - 1);

    logic [15:0] pwm_cnt, pwm_nxt;

    // The PWM phase runs only once the fan is on, and it starts at 0 on the edge entering ETHER.
    // When DUTY >= PERIOD, the compare is always true and fan_en stays high.
    always_comb begin
        pwm_nxt = '0;
        if (fan_on) pwm_nxt = (pwm_cnt == PWM_TC) ? 16'd0 : pwm_cnt + 16'd1;
        fan_nxt = fan_on_nxt && (int'(pwm_nxt) < DUTY_N);
    end

    // PWM phase register.
    always_ff @(posedge clk) begin
        if (reset) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_nxt;
    end
`else
    // No PWM: the fan stays on once it is enabled.
    assign fan_nxt = fan_on_nxt;
`endif

    // State register, plus outputs decoded from the next state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= HOLD;
            cnt             <= '0;
            fan_on          <= 1'b0;
            fan_en          <= 1'b0;
            ether_reset_out <= 1'b1;
            core_reset_out  <= 1'b1;
            ready           <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            fan_on          <= fan_on_nxt;
            fan_en          <= fan_nxt;
            ether_reset_out <= (state_nxt == HOLD);
            core_reset_out  <= (state_nxt == HOLD) || (state_nxt == ETHER);
            ready           <= (state_nxt == RUN);
        end
    end

endmodule

// File: doc/core_reset_sequencer.md
CORE_RESET_SEQUENCER -- requirements
Module: core_reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16, number of cycles reset_req must stay low before sequencing starts.
REQ-002 Parameter ETHER_DELAY, default 8, cycles between ether_reset_out release and core_reset_out release.
REQ-003 Parameter CORE_DELAY, default 8, cycles between core_reset_out release and ready assertion.
REQ-004 Parameter FAN_PWM_PERIOD, default 100, PWM period in cycles (used only with FAN_PWM_EN).
REQ-005 Parameter FAN_PWM_DUTY, default 60, PWM high cycles per period (used only with FAN_PWM_EN).
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 reset_req  input  1  asynchronous reset request from board/PLL domain, active-high.
REQ-009 ether_reset_out  output  1  Ethernet-side reset, active-high, registered.
REQ-010 core_reset_out  output  1  core-logic reset, active-high, registered.
REQ-011 fan_en  output  1  fan enable, registered.
REQ-012 ready  output  1  sequence complete, registered.

Function
REQ-013 reset_req SHALL pass through a 2-flop synchronizer (req_sync); no other logic samples reset_req directly.
REQ-014 FSM states SHALL be HOLD, ETHER, CORE, RUN, with a shared 16-bit cycle counter cleared on every state change.
REQ-015 HOLD: counter increments while req_sync==0, clears to 0 while req_sync==1; on counter reaching HOLD_CYCLES-1 with req_sync==0 -> ETHER.
REQ-016 ETHER: counter increments each cycle; on ETHER_DELAY-1 -> CORE.
REQ-017 CORE: counter increments each cycle; on CORE_DELAY-1 -> RUN.
REQ-018 RUN: held indefinitely until req_sync==1.
REQ-019 req_sync==1 in ETHER, CORE or RUN SHALL force HOLD on the next edge; this SHALL take priority over a simultaneous terminal-count transition.
REQ-020 Outputs SHALL update on the same edge as the state register: ether_reset_out=1 only in HOLD; core_reset_out=1 in HOLD and ETHER; ready=1 only in RUN.
REQ-021 fan_en source ("fan_on") SHALL set on the edge entering ETHER and remain set through any later return to HOLD; only reset clears it.
REQ-022 Any parameter value of 0 SHALL behave as 1.
REQ-023 With defaults and reset_req held low, ether_reset_out SHALL fall 18 cycles after reset deasserts, core_reset_out 8 cycles later (26), ready 8 cycles after that (34).
REQ-024 ether_reset_out and core_reset_out SHALL never be deasserted simultaneously, and core_reset_out SHALL never be low while ether_reset_out is high.

Reset
REQ-025 On reset: state HOLD, counter 0, synchronizer flops 1, ether_reset_out=1, core_reset_out=1, fan_en=0, ready=0, fan_on=0, PWM counter 0.
REQ-026 reset asserted mid-sequence SHALL produce the REQ-025 state on the next edge regardless of current state.

Configuration
REQ-027 Macro FAN_PWM_EN defined: a 16-bit PWM counter wraps 0..FAN_PWM_PERIOD-1 while fan_on; fan_en = fan_on and (pwm_cnt < FAN_PWM_DUTY), registered; DUTY >= PERIOD gives constant high.
REQ-028 FAN_PWM_EN undefined: no PWM counter; fan_en = fan_on registered (constant high once set).

Verification
REQ-029 reset released, reset_req=0, defaults -> ether_reset_out falls at cycle 18, core_reset_out at 26, ready at 34, fan_en rises at 18.
REQ-030 reset_req pulsed high for 1 cycle at cycle 10 (in HOLD) -> hold counter restarts; ether_reset_out falls 18 cycles after the pulse is sampled.
REQ-031 reset_req raised in RUN -> two cycles of sync latency then next edge: ether_reset_out=1, core_reset_out=1, ready=0, fan_en unchanged; full sequence repeats after release.
REQ-032 reset_req sampled high (req_sync==1) on the same edge as CORE terminal count -> state HOLD, ready never asserts.
REQ-033 reset asserted in CORE -> next edge all outputs at reset values, fan_en=0.
REQ-034 FAN_PWM_EN defined, PERIOD=100, DUTY=60 -> in RUN fan_en high 60 cycles, low 40, repeating; undefined -> fan_en constant 1.
